// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - load/store unit to 64-bit memory bus bridge (optional MISALIGN_TRAP_EN)
module lsu_mem_if #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic [1:0]  data_byte_i,
  input  logic        data_wr_i,
  input  logic        zero_extnd_i,
  output logic        rsp_valid_o,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  output logic [63:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_wstrb_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [63:0]   addr_q, wdata_q, rdata_q;
  logic [7:0]    wstrb_q;
  logic [1:0]    size_q;
  logic          wr_q, zext_q, err_q;

  logic          accept, trap_now, timeout;
  logic [63:0]   addr_aligned, wdata_new, shifted, load_ext;
  logic [7:0]    wstrb_new;

  assign accept  = req_valid_i & req_ready_o;
  assign timeout = (cnt_q == CNT_LAST);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  // Misalignment relative to the natural alignment of the access size
  always_comb begin
    misaligned = 1'b0;
    case (data_byte_i)
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = |addr_i[1:0];
      2'b11:   misaligned = |addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end
  assign trap_now = misaligned;
`else
  assign trap_now = 1'b0;
`endif

  // Request address forced to natural alignment, then strobe and lane replication
  always_comb begin
    addr_aligned = addr_i;
    wstrb_new    = 8'h00;
    wdata_new    = 64'h0;
    case (data_byte_i)
      2'b00: begin
        addr_aligned = addr_i;
        wstrb_new    = 8'h01 << addr_aligned[2:0];
        wdata_new    = {8{wdata_i[7:0]}};
      end
      2'b01: begin
        addr_aligned = {addr_i[63:1], 1'b0};
        wstrb_new    = 8'h03 << addr_aligned[2:0];
        wdata_new    = {4{wdata_i[15:0]}};
      end
      2'b10: begin
        addr_aligned = {addr_i[63:2], 2'b00};
        wstrb_new    = 8'h0F << addr_aligned[2:0];
        wdata_new    = {2{wdata_i[31:0]}};
      end
      default: begin
        addr_aligned = {addr_i[63:3], 3'b000};
        wstrb_new    = 8'hFF;
        wdata_new    = wdata_i;
      end
    endcase
    if (!data_wr_i) begin
      wstrb_new = 8'h00;
      wdata_new = 64'h0;
    end
  end

  // Load lane extraction and sign/zero extension by size
  always_comb begin
    shifted  = mem_rdata_i >> {addr_q[2:0], 3'b000};
    load_ext = shifted;
    case (size_q)
      2'b00:   load_ext = zext_q ? {56'h0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'b01:   load_ext = zext_q ? {48'h0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_ext = zext_q ? {32'h0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = trap_now ? RESP : REQ;
      REQ: begin
        if (mem_gnt_i)    state_d = wr_q ? RESP : WAIT;
        else if (timeout) state_d = RESP;
      end
      WAIT: begin
        if (mem_rvalid_i) state_d = RESP;
        else if (timeout) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and REQ/WAIT cycle counter, cleared on every state entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (state_q == REQ || state_q == WAIT) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Request capture and response data/error capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      zext_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          addr_q  <= addr_aligned;
          wdata_q <= wdata_new;
          wstrb_q <= wstrb_new;
          size_q  <= data_byte_i;
          wr_q    <= data_wr_i;
          zext_q  <= zero_extnd_i;
          err_q   <= trap_now;
          rdata_q <= '0;
        end
        REQ:  if (!mem_gnt_i && timeout) err_q <= 1'b1;
        WAIT: begin
          if (mem_rvalid_i) rdata_q <= load_ext;
          else if (timeout) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign mem_req_o   = (state_q == REQ);
  assign mem_addr_o  = mem_req_o ? {addr_q[63:3], 3'b000} : 64'h0;
  assign mem_wr_o    = mem_req_o & wr_q;
  assign mem_wdata_o = mem_req_o ? wdata_q : 64'h0;
  assign mem_wstrb_o = mem_req_o ? wstrb_q : 8'h00;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 64'h0;
  assign rsp_err_o   = rsp_valid_o & err_q;

endmodule

// File: doc/lsu_mem_if.md
LSU_MEM_IF -- requirements
Module: lsu_mem_if

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles spent in REQ or WAIT before abort.
REQ-002 SHALL have port clk  in  1  clock, rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid_i  in  1  memory op request from execute stage.
REQ-005 SHALL have port req_ready_o  out  1  block can accept a request.
REQ-006 SHALL have port addr_i  in  64  byte address.
REQ-007 SHALL have port wdata_i  in  64  store data, right-aligned.
REQ-008 SHALL have port data_byte_i  in  2  size: 00 byte, 01 half, 10 word, 11 double.
REQ-009 SHALL have port data_wr_i  in  1  1 store, 0 load.
REQ-010 SHALL have port zero_extnd_i  in  1  load zero-extend (LBU/LHU/LWU).
REQ-011 SHALL have port rsp_valid_o  out  1  one-cycle completion pulse, no backpressure.
REQ-012 SHALL have port rsp_rdata_o  out  64  extended load result, 0 for stores and errors.
REQ-013 SHALL have port rsp_err_o  out  1  misalign or timeout, valid with rsp_valid_o.
REQ-014 SHALL have ports mem_req_o out 1, mem_addr_o out 64 (bits [2:0]=0), mem_wr_o out 1, mem_wdata_o out 64, mem_wstrb_o out 8.
REQ-015 SHALL have ports mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 64.

Function
REQ-016 SHALL implement FSM IDLE, REQ, WAIT, RESP; req_ready_o = (state==IDLE).
REQ-017 SHALL capture addr/wdata/size/wr/zero_extnd on req_valid_i & req_ready_o and go to REQ.
REQ-018 SHALL hold mem_req_o=1 with stable addr/wr/wdata/wstrb in REQ until mem_gnt_i sampled high.
REQ-019 SHALL on grant go to RESP for stores, WAIT for loads.
REQ-020 SHALL in WAIT capture mem_rdata_i on mem_rvalid_i, go to RESP; rvalid outside WAIT and gnt outside REQ ignored.
REQ-021 SHALL assert rsp_valid_o exactly one cycle in RESP, then return to IDLE.
REQ-022 SHALL give latency accept N -> rsp N+2 (store, immediate grant), N+3 minimum (load).
REQ-023 SHALL drive mem_wstrb_o: B 0x01<<a[2:0], H 0x03<<a[2:0], W 0x0F<<a[2:0], D 0xFF; 0 for loads.
REQ-024 SHALL replicate store lanes: byte x8, half x4, word x2, double as-is.
REQ-025 SHALL extract load lane at a[2:0], sign-extend by size unless zero_extnd set; double ignores zero_extnd.
REQ-026 SHALL treat misaligned as H a[0]!=0, W a[1:0]!=0, D a[2:0]!=0.
REQ-027 SHALL count cycles in REQ/WAIT (reset on entry); at TIMEOUT_CYCLES drop mem_req_o, go RESP, err=1, rdata 0.

Reset
REQ-028 SHALL on reset force IDLE, counter 0, req_ready_o=1, all other outputs 0, immediately (asynchronously).
REQ-029 SHALL abandon any in-flight transaction on reset with no response; late rvalid after reset ignored.

Configuration
REQ-030 SHALL, with MISALIGN_TRAP_EN defined, route misaligned requests IDLE->RESP with no bus activity, rsp_err_o=1 next cycle.
REQ-031 SHALL, with MISALIGN_TRAP_EN undefined, clear offending low address bits to natural alignment and perform the access normally.

Verification
REQ-032 SHALL cover SB addr 0x1003 wdata 0xAB, gnt same cycle -> wstrb 0x08, wdata 0xABAB..AB, rsp N+2, err 0.
REQ-033 SHALL cover LB addr 0x2005, rdata 0x0000_80xx_..., byte 0x80 -> rsp_rdata 0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
REQ-034 SHALL cover LW addr 0x10, gnt delayed 3 cycles, rvalid 2 later -> mem_req held stable 4 cycles, correct word.
REQ-035 SHALL cover LD addr 0x0C with MISALIGN_TRAP_EN -> no mem_req, err 1; without -> access at 0x08.
REQ-036 SHALL cover no gnt for 64 cycles -> mem_req drops, rsp_valid 1, err 1; reset mid-WAIT -> IDLE, no rsp.
